// File: rtl/def.sv
// Shared core definitions: decoded instruction set, MEM-stage FSM states and
// helpers that classify memory instructions.
package def;

    typedef enum logic [5:0] {
        NOP, ADD, SUB, AND_, OR_, XOR_, SLL, SRL, SRA, SLT, SLTU,
        ADDI, LUI, AUIPC, JAL, JALR, BEQ, BNE,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        FLW, FSW, FADD, FMUL
    } instructions;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        FIN
    } mem_state_t;

    function automatic logic is_load(input instructions i);
        return i inside {LB, LH, LW, LBU, LHU, FLW};
    endfunction

    function automatic logic is_store(input instructions i);
        return i inside {SB, SH, SW, FSW};
    endfunction

    // Natural alignment check; byte accesses can never be misaligned.
    function automatic logic access_misaligned(input instructions i, input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (i)
            LH, LHU, SH:      m = a[0];
            LW, SW, FLW, FSW: m = (a != 2'b00);
            default:          m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or
// zero-extends it according to the load instruction.
module load_extend
    import def::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  instructions instr,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (instr)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'b0, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'b0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: runs one load or store over a valid/ready data port
// and returns the write-back value with a one-cycle done pulse.
module mem_access
    import def::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  instructions           instr,
    input  logic [31:0]           addr,
    input  logic [31:0]           rs2_v,
    input  logic [31:0]           frs2_v,
    input  logic                  mem_read_enabled,
    input  logic                  mem_write_enabled,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           result,
    output logic                  done,
    output logic                  busy,
    output logic                  misaligned
);

    mem_state_t  state, state_nx;
    logic        is_mem;
    logic        reject;
    logic        accept;
    logic [1:0]  addr_lo;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] st_src;
    logic [31:0] ld_data;

    assign is_mem = is_load(instr) || is_store(instr);
    // Conflicting read/write flags are rejected the same way as a bad alignment.
    assign reject = (mem_read_enabled && mem_write_enabled)
                 || (is_mem && access_misaligned(instr, addr[1:0]));
    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = (reject || !is_mem) ? FIN : REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ready) state_nx = mem_we ? FIN : WAIT_R;
            end
            WAIT_R: begin
                if (mem_rvalid) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        st_src  = (instr == FSW) ? frs2_v : rs2_v;
        st_strb = 4'b0000;
        st_data = 32'b0;
        case (instr)
            SB: begin
                st_data = {4{st_src[7:0]}};
                st_strb = 4'b0001 << addr[1:0];
            end
            SH: begin
                st_data = {2{st_src[15:0]}};
                st_strb = addr[1] ? 4'b1100 : 4'b0011;
            end
            SW, FSW: begin
                st_data = st_src;
                st_strb = 4'b1111;
            end
            default: begin
                st_data = 32'b0;
                st_strb = 4'b0000;
            end
        endcase
    end

    load_extend u_load_extend (
        .rdata (mem_rdata),
        .addr  (addr_lo),
        .instr (instr),
        .data  (ld_data)
    );

    // Bus fields are captured once at start so they hold through any stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= 4'b0;
            mem_wdata  <= 32'b0;
            result     <= 32'b0;
            misaligned <= 1'b0;
            addr_lo    <= 2'b0;
        end else begin
            if (accept) begin
                misaligned <= reject;
                addr_lo    <= addr[1:0];
                if (reject) begin
                    result <= 32'b0;
                end else if (!is_mem) begin
                    result <= addr;
                end else begin
                    mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_we    <= is_store(instr);
                    mem_wstrb <= st_strb;
                    mem_wdata <= st_data;
                end
            end
            if (state == WAIT_R && mem_rvalid) result <= ld_data;
        end
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the multi-cycle core, directly downstream of the execute stage. It consumes the execute stage's latched result (effective address), decoded instruction and `mem_read_enabled` / `mem_write_enabled` flags. It runs one load or store over a valid/ready data-memory port, handling byte/half/word lanes, sign/zero extension and alignment checks. It returns the write-back value with a one-cycle `done` pulse.

## Interface
- `ADDR_WIDTH`, 32, width of `mem_addr`; upper address bits beyond this are dropped.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; the control FSM is entering the MEM state.
- `instr`  in  `instructions`  decoded instruction, held stable from `start` to `done`.
- `addr`  in  32  effective address (execute `result`).
- `rs2_v`, `frs2_v`  in  32 each  store data; `frs2_v` is used for `fsw`.
- `mem_read_enabled`, `mem_write_enabled`  in  1 each  execute-stage flags.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  write request.
- `mem_addr`  out  ADDR_WIDTH  word-aligned byte address (`addr[1:0]` forced to 0).
- `mem_wstrb`  out  4  byte-lane enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  request accepted.
- `mem_rvalid`, `mem_rdata`  in  1, 32  read response.
- `result`  out  32  write-back value.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `misaligned`  out  1  sticky until the next `start`; the access was rejected.

## Operation
- FSM states: IDLE, REQ, WAIT_R, FIN.
- IDLE with `start`:
  - Non-memory instruction: capture `result <= addr` and go to FIN.
  - Misaligned access: set `misaligned` and go to FIN with `result = 0`. Misaligned means half with `addr[0]=1`, or word / `flw` / `fsw` with `addr[1:0]!=0`.
  - Both `mem_read_enabled` and `mem_write_enabled` high: treat as misaligned.
  - Otherwise go to REQ.
- REQ:
  - `mem_req=1`; `mem_addr`, `mem_we`, `mem_wstrb` and `mem_wdata` are registered and stable until accepted.
  - On `mem_ready`: writes go to FIN, reads go to WAIT_R.
- WAIT_R: on `mem_rvalid`, latch the extended load data into `result`, then go to FIN.
- FIN: `done=1` for one cycle, then IDLE.
- `start` while not in IDLE is ignored. `mem_rvalid` outside WAIT_R is ignored.
- Stores:
  - `sb`: `wdata = {4{d[7:0]}}`, `wstrb = 4'b0001 << addr[1:0]`.
  - `sh`: `wdata = {2{d[15:0]}}`, `wstrb = addr[1] ? 4'b1100 : 4'b0011`.
  - `sw` / `fsw`: `wstrb = 4'b1111`.
  - `mem_wstrb = 0` for reads.
- Loads: select lane by `addr[1:0]`.
  - `lb` / `lh`: sign-extend.
  - `lbu` / `lhu`: zero-extend.
  - `lw` / `flw`: full word.
- `rst` at any cycle: next state IDLE. All outputs go to 0 the next edge, including dropping an in-flight `mem_req`; a pending `rvalid` is discarded.

## Timing
- Reset values: `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata`, `result`, `done`, `busy`, `misaligned` are all 0.
- `start` at cycle 0 means `mem_req` is high in cycle 1.
- Store with `mem_ready` in cycle 1: `done` in cycle 2.
- Load accepted in cycle 1 with `mem_rvalid` in cycle 2: `result` is valid and `done` is high in cycle 3.
- Non-memory or misaligned: `done` in cycle 1, and no `mem_req` is ever issued.
- Each `mem_ready` stall cycle adds one cycle; bus outputs stay unchanged while stalled.
- `mem_rvalid` in the same cycle as `mem_ready` is not accepted. The bus guarantees the response arrives at least one cycle after acceptance.
- `result` holds its value after `done` until the next `start` completes.

## Structure
- Add the `mem_state_t` enum (IDLE/REQ/WAIT_R/FIN) to the shared `def.sv` package. Reuse `instructions` from the same package.
- One combinational sub-module, `load_extend`: inputs `rdata`, `addr[1:0]`, `instr`; output is the extended 32-bit value.
- Store lane formation stays inline.

## Test plan
- `lw` at 0x100, `mem_ready` in cycle 1, `rdata=0xDEADBEEF` in cycle 2 -> `mem_addr=0x100`, `wstrb=0`, `result=0xDEADBEEF`, `done` in cycle 3.
- `lb` / `lbu` at 0x103, `rdata=0x80FF_0000` -> `mem_addr=0x100`, `result` 0xFFFFFF80 / 0x00000080.
- `sh` at 0x102, `rs2_v=0x1234ABCD`, `mem_ready` held low 4 cycles -> `wdata=0xABCDABCD`, `wstrb=1100`, outputs stable while stalled, `done` 1 cycle after `ready`.
- `lw` at 0x102 -> `misaligned=1`, `result=0`, `done` in cycle 1, `mem_req` never high.
- `add` with `addr=0x55` -> `result=0x55`, `done` in cycle 1, no request.
- `rst` in WAIT_R, late `rvalid` in the next cycle -> IDLE, outputs 0, `rvalid` ignored; a following `start` works normally.
